// File: rtl/fread_hex_dump_pkg.sv
// Shared types and helpers for the file-read hex dumper: FSM encoding,
// ASCII control characters and the nibble-to-hex conversion.
package fread_hex_dump_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_FILL,
    ST_HEX_HI,
    ST_HEX_LO,
    ST_SEP,
    ST_CR,
    ST_LF
  } state_t;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_SP = 8'h20;

  // Uppercase hex digit: '0'..'9' then 'A'..'F' (0x37 + 10 = 'A').
  function automatic logic [7:0] nib2hex(input logic [3:0] nib);
    return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
  endfunction

endpackage

// File: rtl/hex_nibble_enc.sv
// Combinational 4-bit to uppercase ASCII hex digit encoder.
module hex_nibble_enc
  import fread_hex_dump_pkg::*;
(
  input  logic [3:0] nib,
  output logic [7:0] asc
);

  assign asc = nib2hex(nib);

endmodule

// File: rtl/fread_hex_dump.sv
// Requests LEN bytes of a file from the fread stage, buffers them, then
// streams them to a UART as "HH HH ..\r\n" lines of BPL bytes.
module fread_hex_dump
  import fread_hex_dump_pkg::*;
#(
  parameter logic [31:0] FILE_ID = 32'hDABBAD00,
  parameter int          LEN     = 64,
  parameter int          BPL     = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [31:0] req_file_id,
  output logic [31:0] req_offset,
  output logic [9:0]  req_len,
  output logic        req_valid,
  input  logic        req_ready,
  input  logic [7:0]  resp_data,
  input  logic        resp_valid,
  output logic [7:0]  uart_data,
  output logic        uart_valid,
  input  logic        uart_ack,
  output logic        busy,
  output logic        done
);

  localparam int CW = $clog2(LEN + 1);
  localparam int AW = (LEN > 1) ? $clog2(LEN) : 1;
  localparam int LW = $clog2(BPL + 1);
  localparam logic [CW-1:0] LAST     = CW'(LEN - 1);
  localparam logic [CW-1:0] ONE      = CW'(1);
  localparam logic [LW-1:0] COL_LAST = LW'(BPL - 1);
  localparam logic [LW-1:0] COL_ONE  = LW'(1);

  state_t        state, state_nxt;
  logic [CW-1:0] wr_ptr, wr_ptr_nxt, rd_ptr, rd_ptr_nxt;
  logic [LW-1:0] col, col_nxt;
  logic          uart_valid_nxt, done_nxt;
  logic          we, acked, is_char, last, eol;

  logic [7:0]    mem [0:(1<<AW)-1];
  logic [7:0]    ram_q, byp_data, cur_byte, hi_asc, lo_asc, ch;
  logic          byp;

  assign req_file_id = FILE_ID;
  assign req_offset  = 32'h0;
  assign req_len     = 10'(LEN - 1);
  assign req_valid   = (state == ST_REQ);
  assign busy        = (state != ST_IDLE);

  assign we      = (state == ST_FILL) && resp_valid;
  assign acked   = uart_valid && uart_ack;
  assign is_char = (state == ST_HEX_HI) || (state == ST_HEX_LO) || (state == ST_SEP) ||
                   (state == ST_CR) || (state == ST_LF);
  assign last    = (rd_ptr == LAST);
  assign eol     = last || (col == COL_LAST);

  always_comb begin
    state_nxt  = state;
    wr_ptr_nxt = wr_ptr;
    rd_ptr_nxt = rd_ptr;
    col_nxt    = col;
    done_nxt   = 1'b0;
    case (state)
      ST_IDLE: if (start) begin
        state_nxt  = ST_REQ;
        wr_ptr_nxt = '0;
        rd_ptr_nxt = '0;
        col_nxt    = '0;
      end
      ST_REQ:  if (req_ready) state_nxt = ST_FILL;
      ST_FILL: if (resp_valid) begin
        if (wr_ptr == LAST) state_nxt = ST_HEX_HI;
        else                wr_ptr_nxt = wr_ptr + ONE;
      end
      ST_HEX_HI: if (acked) state_nxt = ST_HEX_LO;
      ST_HEX_LO: if (acked) state_nxt = eol ? ST_CR : ST_SEP;
      ST_SEP: if (acked) begin
        state_nxt  = ST_HEX_HI;
        rd_ptr_nxt = rd_ptr + ONE;
        col_nxt    = col + COL_ONE;
      end
      ST_CR: if (acked) state_nxt = ST_LF;
      ST_LF: if (acked) begin
        if (last) begin
          state_nxt = ST_IDLE;
          done_nxt  = 1'b1;
        end else begin
          state_nxt  = ST_HEX_HI;
          rd_ptr_nxt = rd_ptr + ONE;
          col_nxt    = '0;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    // Raised straight out of FILL so the first digit is offered in the first
    // HEX_HI cycle; afterwards one idle cycle follows every ack.
    uart_valid_nxt = (is_char && !acked) || ((state == ST_FILL) && (state_nxt == ST_HEX_HI));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      col        <= '0;
      uart_valid <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_nxt;
      wr_ptr     <= wr_ptr_nxt;
      rd_ptr     <= rd_ptr_nxt;
      col        <= col_nxt;
      uart_valid <= uart_valid_nxt;
      done       <= done_nxt;
    end
  end

  // Read is addressed by the next pointer so ram_q already holds mem[rd_ptr];
  // the bypass covers a read of the byte being written this cycle.
  always_ff @(posedge clk) begin
    if (we) mem[wr_ptr[AW-1:0]] <= resp_data;
    ram_q    <= mem[rd_ptr_nxt[AW-1:0]];
    byp      <= we && (wr_ptr == rd_ptr_nxt);
    byp_data <= resp_data;
  end

  assign cur_byte = byp ? byp_data : ram_q;

  hex_nibble_enc u_enc_hi (.nib(cur_byte[7:4]), .asc(hi_asc));
  hex_nibble_enc u_enc_lo (.nib(cur_byte[3:0]), .asc(lo_asc));

  always_comb begin
    ch = 8'h00;
    case (state)
      ST_HEX_HI: ch = hi_asc;
      ST_HEX_LO: ch = lo_asc;
      ST_SEP:    ch = ASCII_SP;
      ST_CR:     ch = ASCII_CR;
      ST_LF:     ch = ASCII_LF;
      default:   ch = 8'h00;
    endcase
  end

  assign uart_data = uart_valid ? ch : 8'h00;

endmodule

// File: tb/tb_fread_hex_dump.sv
// Randomized scoreboard bench: a text model queues the expected dump, a
// UART-side monitor acks with random delays and pops/compares each char.
module tb_fread_hex_dump;

  localparam int          LEN = 40;
  localparam int          BPL = 16;
  localparam logic [31:0] FID = 32'hDABBAD00;

  logic        clk = 1'b0, rst = 1'b0, start = 1'b0, req_ready = 1'b0;
  logic        resp_valid = 1'b0, uart_ack = 1'b0;
  logic [7:0]  resp_data = 8'h00;
  logic [31:0] req_file_id, req_offset;
  logic [9:0]  req_len;
  logic        req_valid, uart_valid, busy, done;
  logic [7:0]  uart_data;

  int          checks = 0, failures = 0;
  int          done_total = 0, char_total = 0, ack_max = 0;
  logic [7:0]  exp_q [$];
  logic [7:0]  data [LEN];
  string       hexs = "0123456789ABCDEF";

  always #5 clk = ~clk;

  fread_hex_dump #(.FILE_ID(FID), .LEN(LEN), .BPL(BPL)) dut (
    .clk(clk), .rst(rst), .start(start),
    .req_file_id(req_file_id), .req_offset(req_offset), .req_len(req_len),
    .req_valid(req_valid), .req_ready(req_ready),
    .resp_data(resp_data), .resp_valid(resp_valid),
    .uart_data(uart_data), .uart_valid(uart_valid), .uart_ack(uart_ack),
    .busy(busy), .done(done)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected text: two hex digits per byte, then CRLF at line end or dump end, else a space.
  task automatic model();
    for (int i = 0; i < LEN; i++) begin
      exp_q.push_back(8'(hexs[int'(data[i][7:4])]));
      exp_q.push_back(8'(hexs[int'(data[i][3:0])]));
      if (i == LEN - 1 || (i + 1) % BPL == 0) begin
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
      end else begin
        exp_q.push_back(8'h20);
      end
    end
  endtask

  always @(negedge clk) if (done === 1'b1) done_total++;

  // UART consumer / monitor
  initial begin
    logic [7:0] d;
    int w;
    forever begin
      @(negedge clk);
      if (uart_valid === 1'b1) begin
        d = uart_data;
        w = (ack_max == 0) ? 0 : $urandom_range(0, ack_max);
        for (int k = 0; k < w; k++) begin
          @(negedge clk);
          chk("uart_hold", {23'h0, uart_valid, uart_data}, {23'h0, 1'b1, d});
        end
        uart_ack = 1'b1;
        @(negedge clk);
        uart_ack = 1'b0;
        chk("valid_drop", {31'h0, uart_valid}, 32'h0);
        char_total++;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL spurious_char: got %02h expected none", d);
        end else begin
          chk("uart_char", {24'h0, d}, {24'h0, exp_q.pop_front()});
        end
      end
    end
  end

  task automatic run(input bit noise, input bit abort, input bit start_mid);
    int n, d0, c0;
    bit got;
    d0 = done_total;
    c0 = char_total;
    if (noise) repeat (2) begin
      @(negedge clk); resp_valid = 1'b1; resp_data = 8'($urandom);
      @(negedge clk); resp_valid = 1'b0;
    end
    if (!abort) model();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    n = 0;
    while (req_valid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    chk("req_valid_rise", {31'h0, req_valid}, 32'h1);
    repeat (3) begin
      @(negedge clk);
      if (noise) begin resp_valid = 1'($urandom_range(0, 1)); resp_data = 8'($urandom); end
    end
    resp_valid = 1'b0;
    req_ready = 1'b1;
    @(negedge clk);
    req_ready = 1'b0;
    chk("req_valid_drop", {31'h0, req_valid}, 32'h0);
    chk("busy_fill", {31'h0, busy}, 32'h1);
    for (int i = 0; i < LEN; i++) begin
      if ($urandom_range(0, 3) == 0) begin resp_valid = 1'b0; @(negedge clk); end
      resp_valid = 1'b1;
      resp_data  = data[i];
      @(negedge clk);
      if (abort && i == 9) break;
    end
    if (abort) begin
      resp_valid = 1'b0;
      rst = 1'b0;
      #1;
      chk("rst_busy", {31'h0, busy}, 32'h0);
      chk("rst_req_valid", {31'h0, req_valid}, 32'h0);
      chk("rst_uart_valid", {31'h0, uart_valid}, 32'h0);
      chk("rst_uart_data", {24'h0, uart_data}, 32'h0);
      chk("rst_done", {31'h0, done}, 32'h0);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      chk("abort_no_done", done_total - d0, 0);
      chk("abort_no_chars", char_total - c0, 0);
      return;
    end
    // stray bytes after the last one must be ignored
    repeat (2) begin resp_valid = 1'b1; resp_data = 8'($urandom); @(negedge clk); end
    resp_valid = 1'b0;
    n = 0;
    got = 1'b0;
    while (!got && n < 8000) begin
      @(negedge clk);
      start = start_mid && (n == 50);
      if (done === 1'b1) got = 1'b1;
      n++;
    end
    start = 1'b0;
    chk("done_seen", {31'h0, got}, 32'h1);
    repeat (4) @(negedge clk);
    chk("done_count", done_total - d0, 1);
    chk("busy_end", {31'h0, busy}, 32'h0);
    chk("char_total", char_total - c0, 3 * LEN + (LEN + BPL - 1) / BPL);
    chk("chars_left", exp_q.size(), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_busy", {31'h0, busy}, 32'h0);
    chk("reset_req_valid", {31'h0, req_valid}, 32'h0);
    chk("reset_uart_valid", {31'h0, uart_valid}, 32'h0);
    chk("reset_uart_data", {24'h0, uart_data}, 32'h0);
    chk("reset_done", {31'h0, done}, 32'h0);
    rst = 1'b1;
    @(negedge clk);
    chk("req_file_id", req_file_id, FID);
    chk("req_offset", req_offset, 32'h0);
    chk("req_len", {22'h0, req_len}, LEN - 1);

    // back-to-back acks, structured bytes covering 00 and FF
    ack_max = 0;
    for (int i = 0; i < LEN; i++) data[i] = 8'(i * 17);
    run(1'b1, 1'b0, 1'b0);

    // random data, slow acks, start pulsed mid-dump
    ack_max = 20;
    for (int i = 0; i < LEN; i++) data[i] = 8'($urandom);
    run(1'b1, 1'b0, 1'b1);

    // reset after 10 fill bytes, then a clean full run
    for (int i = 0; i < LEN; i++) data[i] = 8'($urandom);
    run(1'b0, 1'b1, 1'b0);
    ack_max = 3;
    for (int i = 0; i < LEN; i++) data[i] = 8'($urandom);
    run(1'b1, 1'b0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fread_hex_dump.md
FREAD_HEX_DUMP -- requirements
Module: fread_hex_dump

Interface
REQ-001 The module SHALL have parameter FILE_ID, default 32'hDABBAD00, the ESP32 file ID to read.
REQ-002 The module SHALL have parameter LEN, default 64, the bytes per transfer; legal range 1..1024.
REQ-003 The module SHALL have parameter BPL, default 16, the bytes per output text line.
REQ-004 clk  in  1  single system clock; all logic on posedge.
REQ-005 rst  in  1  asynchronous, active-low reset (asserted at 0).
REQ-006 start  in  1  one-cycle pulse that begins a read-and-dump.
REQ-007 req_file_id  out  32  constant FILE_ID.
REQ-008 req_offset  out  32  constant 0.
REQ-009 req_len  out  10  constant LEN-1.
REQ-010 req_valid  out  1  file read request to the fread stage.
REQ-011 req_ready  in  1  request accepted by the fread stage.
REQ-012 resp_data  in  8  streamed file byte.
REQ-013 resp_valid  in  1  resp_data valid this cycle; there is no backpressure.
REQ-014 uart_data  out  8  ASCII character to the UART transmitter.
REQ-015 uart_valid  out  1  uart_data valid.
REQ-016 uart_ack  in  1  character consumed.
REQ-017 busy  out  1  high in every state except IDLE.
REQ-018 done  out  1  one-cycle pulse when the last character is acknowledged.

Function
REQ-019 The FSM SHALL have the states IDLE, REQ, FILL, HEX_HI, HEX_LO, SEP, CR, LF.
REQ-020 In IDLE, start=1 SHALL go to REQ, clear byte counter and read pointer; start outside IDLE SHALL be ignored.
REQ-021 In REQ, req_valid SHALL be 1; on req_valid&req_ready the FSM SHALL go to FILL the next cycle and drop req_valid.
REQ-022 In FILL, each resp_valid SHALL write resp_data to mem[wr_ptr] and increment wr_ptr; writing byte LEN-1 SHALL go to HEX_HI.
REQ-023 resp_valid in any state other than FILL SHALL be ignored, with no write and no pointer change.
REQ-024 mem SHALL be LEN x 8, synchronous read; read latency SHALL be hidden, so the first character is valid in the first HEX_HI cycle.
REQ-025 HEX_HI SHALL emit the upper nibble and HEX_LO the lower nibble, each as uppercase ASCII ('0'-'9', 'A'-'F').
REQ-026 After HEX_LO: if rd_ptr=LEN-1 or (rd_ptr+1) mod BPL=0, go to CR, then LF; otherwise go to SEP, which emits 0x20.
REQ-027 After SEP or LF, rd_ptr SHALL increment and return to HEX_HI; after LF with rd_ptr=LEN-1, go to IDLE and pulse done.
REQ-028 UART handshake: uart_valid SHALL rise on entering a character state and stay high with uart_data stable until uart_ack.
REQ-029 uart_valid SHALL drop the cycle after the ack, and the state advances on the ack; back-to-back characters SHALL be allowed, with at most one idle cycle between them.
REQ-030 Total characters per run SHALL be 3*LEN + ceil(LEN/BPL).
REQ-031 Counters SHALL be clog2(LEN+1) bits wide and SHALL never wrap past LEN-1.

Reset
REQ-032 rst=0 at any time, including mid-FILL or mid-dump, SHALL force IDLE, req_valid=0, uart_valid=0, uart_data=0, busy=0, done=0, and pointers=0.
REQ-033 mem contents SHALL not be reset.
REQ-034 After rst is released, the first start SHALL begin a clean run.

Structure
REQ-035 Shared package: FSM state encoding, the ASCII constants (CR 0x0D, LF 0x0A, SP 0x20), and the nibble-to-hex function.
REQ-036 One sub-module, hex_nibble_enc (4-bit in, 8-bit ASCII out, combinational); mem SHALL be inferred as iCE40 BRAM or LUT RAM.
REQ-037 The module SHALL be instantiated between spi_dev_fread (STREAM interface) and uart_tx, with its uart_* signals muxed with other UART sources at top level.

Verification
REQ-038 LEN=4, BPL=16; start; req_ready after 3 cycles; bytes 0x00,0xAB,0x5F,0xFF -> UART "00 AB 5F FF\r\n" (13 chars), done pulses once, busy falls.
REQ-039 LEN=32, BPL=16; bytes 0..31 -> exactly two lines, CRLF after "0F" and after "1F", 98 chars total.
REQ-040 uart_ack delayed 0-20 random cycles -> uart_data stable while uart_valid=1, no lost or duplicated characters.
REQ-041 resp_valid pulses in IDLE/REQ, and 2 extra bytes after the last byte -> ignored; dump content unchanged.
REQ-042 rst=0 asserted after 10 of 64 FILL bytes -> outputs at reset values immediately; a new start yields a correct full dump.
REQ-043 start pulsed during a dump -> no effect; exactly one done pulse per run.
